// File: rtl/icache_port_arbiter.sv
// Arbitrates the single icache request port between fetch (primary) and the next-line prefetcher.
// Optional WAIT watchdog enabled by defining ICACHE_ARB_TIMEOUT_EN.
module icache_port_arbiter #(
    parameter int ADDR_SIZE      = 40,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_req_valid_i,
    input  logic [ADDR_SIZE-1:0]  fetch_req_vaddr_i,
    output logic                  fetch_req_ready_o,
    input  logic                  fetch_kill_i,
    output logic                  fetch_resp_valid_o,
    input  logic                  pf_req_valid_i,
    input  logic [ADDR_SIZE-1:0]  pf_req_vaddr_i,
    output logic                  pf_req_ready_o,
    output logic                  pf_resp_valid_o,
    input  logic                  icache_req_ready_i,
    output logic                  icache_req_valid_o,
    output logic [ADDR_SIZE-13:0] icache_req_bits_vpn_o,
    output logic [11:0]           icache_req_bits_idx_o,
    output logic                  icache_req_kill_o,
    input  logic                  icache_resp_valid_i,
    input  logic [ADDR_SIZE-1:0]  icache_resp_vaddr_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    // Handshake: a request transfers on the cycle where valid and ready are both high;
    // resp_valid and kill are single-cycle pulses with no handshake.
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_t                 state_q, state_d;
    logic                   owner_pf_q;
    logic                   merged_q;
    logic [ADDR_SIZE-1:0]   vaddr_q;
    logic [2:0]             starve_q;

    logic                   starved, grant_pf, grant_f, idle_req, idle_fire;
    logic                   resp_match, fetch_same, wait_kill_f, preempt, merge, tmo_hit;
    logic [ADDR_SIZE-1:0]   idle_addr, out_addr;
    logic                   unused_resp_offset;

    assign unused_resp_offset = ^icache_resp_vaddr_i[3:0];

    assign starved   = (starve_q == STARVE_MAX);
    assign grant_pf  = pf_req_valid_i & (~fetch_req_valid_i | starved);
    assign grant_f   = fetch_req_valid_i & ~grant_pf;
    // A flushed fetch never reaches the icache, even if it would have won.
    assign idle_req  = grant_pf | (grant_f & ~fetch_kill_i);
    assign idle_fire = (state_q == S_IDLE) & idle_req & icache_req_ready_i;
    assign idle_addr = grant_pf ? pf_req_vaddr_i :
                       (grant_f ? fetch_req_vaddr_i : '0);

    // Line granularity is 16 bytes, so the low nibble never takes part in a match.
    assign resp_match  = icache_resp_valid_i &
                         (icache_resp_vaddr_i[ADDR_SIZE-1:4] == vaddr_q[ADDR_SIZE-1:4]);
    assign fetch_same  = (fetch_req_vaddr_i[ADDR_SIZE-1:4] == vaddr_q[ADDR_SIZE-1:4]);
    assign wait_kill_f = ~owner_pf_q & fetch_kill_i;
    assign preempt     = owner_pf_q & fetch_req_valid_i & ~fetch_same;
    assign merge       = owner_pf_q & fetch_req_valid_i & fetch_same & ~merged_q & ~fetch_kill_i;

`ifdef ICACHE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    assign tmo_hit   = (state_q == S_WAIT) & (tmo_cnt_q == TMO_LAST);
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (idle_fire) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_WAIT && !tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_hit && !resp_match) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    localparam bit unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            owner_pf_q <= 1'b0;
            merged_q   <= 1'b0;
            vaddr_q    <= '0;
            starve_q   <= '0;
        end else begin
            state_q <= state_d;
            if (idle_fire) begin
                owner_pf_q <= grant_pf;
                vaddr_q    <= idle_addr;
                merged_q   <= 1'b0;
            end else if (state_q == S_WAIT) begin
                if (state_d == S_IDLE) begin
                    merged_q <= 1'b0;
                end else if (merge) begin
                    merged_q <= 1'b1;
                end else if (merged_q && fetch_kill_i) begin
                    merged_q <= 1'b0;
                end
            end
            if (!pf_req_valid_i) begin
                starve_q <= '0;
            end else if (idle_fire) begin
                if (grant_pf) begin
                    starve_q <= '0;
                end else if (!starved) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (idle_fire) state_d = S_WAIT;
            S_WAIT:  if (resp_match || tmo_hit || wait_kill_f || preempt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_req_ready_o  = 1'b0;
        pf_req_ready_o     = 1'b0;
        fetch_resp_valid_o = 1'b0;
        pf_resp_valid_o    = 1'b0;
        icache_req_valid_o = 1'b0;
        icache_req_kill_o  = 1'b0;
        busy_o             = 1'b0;
        out_addr           = idle_addr;
        if (state_q == S_IDLE) begin
            icache_req_valid_o = idle_req;
            fetch_req_ready_o  = grant_f & ~fetch_kill_i & icache_req_ready_i;
            pf_req_ready_o     = grant_pf & icache_req_ready_i;
        end else begin
            busy_o   = 1'b1;
            out_addr = vaddr_q;
            if (resp_match) begin
                fetch_resp_valid_o = ~owner_pf_q | merged_q;
                pf_resp_valid_o    = owner_pf_q;
            end else if (tmo_hit || wait_kill_f || preempt) begin
                icache_req_kill_o = 1'b1;
            end else if (merge) begin
                fetch_req_ready_o = 1'b1;
            end
        end
        icache_req_bits_vpn_o = out_addr[ADDR_SIZE-1:12];
        icache_req_bits_idx_o = out_addr[11:0];
    end

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Vector-table bench for icache_port_arbiter; covers the timeout watchdog when ICACHE_ARB_TIMEOUT_EN is defined.
module tb_icache_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_req_valid_i, fetch_kill_i, pf_req_valid_i;
    logic [39:0] fetch_req_vaddr_i, pf_req_vaddr_i, icache_resp_vaddr_i;
    logic        icache_req_ready_i, icache_resp_valid_i;
    logic        fetch_req_ready_o, fetch_resp_valid_o, pf_req_ready_o, pf_resp_valid_o;
    logic        icache_req_valid_o, icache_req_kill_o, busy_o, timeout_o;
    logic [27:0] icache_req_bits_vpn_o;
    logic [11:0] icache_req_bits_idx_o;

    icache_port_arbiter #(.ADDR_SIZE(40), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fetch_req_valid_i(fetch_req_valid_i), .fetch_req_vaddr_i(fetch_req_vaddr_i),
        .fetch_req_ready_o(fetch_req_ready_o), .fetch_kill_i(fetch_kill_i),
        .fetch_resp_valid_o(fetch_resp_valid_o),
        .pf_req_valid_i(pf_req_valid_i), .pf_req_vaddr_i(pf_req_vaddr_i),
        .pf_req_ready_o(pf_req_ready_o), .pf_resp_valid_o(pf_resp_valid_o),
        .icache_req_ready_i(icache_req_ready_i), .icache_req_valid_o(icache_req_valid_o),
        .icache_req_bits_vpn_o(icache_req_bits_vpn_o), .icache_req_bits_idx_o(icache_req_bits_idx_o),
        .icache_req_kill_o(icache_req_kill_o),
        .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_vaddr_i(icache_resp_vaddr_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        fv;
        logic [39:0] fa;
        logic        fk;
        logic        pv;
        logic [39:0] pa;
        logic        ir;
        logic        rv;
        logic [39:0] ra;
        logic [47:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [47:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [47:0] act;

    assign act = {fetch_req_ready_o, fetch_resp_valid_o, pf_req_ready_o, pf_resp_valid_o,
                  icache_req_valid_o, icache_req_bits_vpn_o, icache_req_bits_idx_o,
                  icache_req_kill_o, busy_o, timeout_o};

    localparam logic [39:0] Z  = 40'h0;
    localparam logic [39:0] F  = 40'h1000;
    localparam logic [39:0] P  = 40'h8000;

    function automatic logic [47:0] e(input logic frdy, input logic fresp, input logic prdy,
                                      input logic presp, input logic ival, input logic [39:0] a,
                                      input logic kill, input logic busy, input logic tmo);
        return {frdy, fresp, prdy, presp, ival, a[39:12], a[11:0], kill, busy, tmo};
    endfunction

    function automatic void add(input string n, input logic fv, input logic [39:0] fa,
                                input logic fk, input logic pv, input logic [39:0] pa,
                                input logic ir, input logic rv, input logic [39:0] ra,
                                input logic [47:0] ex);
        vec_t v;
        v.name = n; v.fv = fv; v.fa = fa; v.fk = fk; v.pv = pv; v.pa = pa;
        v.ir = ir; v.rv = rv; v.ra = ra; v.exp = ex;
        tbl.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        fetch_req_valid_i   = v.fv;
        fetch_req_vaddr_i   = v.fa;
        fetch_kill_i        = v.fk;
        pf_req_valid_i      = v.pv;
        pf_req_vaddr_i      = v.pa;
        icache_req_ready_i  = v.ir;
        icache_resp_valid_i = v.rv;
        icache_resp_vaddr_i = v.ra;
    endtask

    task automatic check(input string name);
        logic [47:0] want;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %h, no expected entry queued", name, act);
        end else begin
            want = exp_q.pop_front();
            if (act !== want) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", name, act, want);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        exp_q.push_back(v.exp);
        #4;
        check(v.name);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vec_t v;
        drive('{name: "zero", fv: 0, fa: Z, fk: 0, pv: 0, pa: Z, ir: 0, rv: 0, ra: Z, exp: '0});

        // fetch-only transaction, idle-cycle behaviour
        add("fo_grant",     1, 40'h1234, 0, 0, Z, 1, 0, Z,        e(1,0,0,0,1,40'h1234,0,0,0));
        add("fo_wait",      0, Z,        0, 0, Z, 1, 0, Z,        e(0,0,0,0,0,40'h1234,0,1,0));
        add("fo_resp_miss", 0, Z,        0, 0, Z, 1, 1, 40'h1244, e(0,0,0,0,0,40'h1234,0,1,0));
        add("fo_resp",      0, Z,        0, 0, Z, 1, 1, 40'h1230, e(0,1,0,0,0,40'h1234,0,1,0));
        add("idle_quiet",   0, Z,        0, 0, Z, 1, 0, Z,        e(0,0,0,0,0,Z,0,0,0));
        add("idle_resp",    0, Z,        0, 0, Z, 1, 1, 40'h1230, e(0,0,0,0,0,Z,0,0,0));
        add("icache_busy",  1, 40'h5000, 0, 0, Z, 0, 0, Z,        e(0,0,0,0,1,40'h5000,0,0,0));
        add("idle_kill",    1, 40'h5000, 1, 0, Z, 1, 0, Z,        e(0,0,0,0,0,40'h5000,0,0,0));
        // contention: four fetch grants then one forced prefetch grant
        for (int i = 1; i <= 4; i++) begin
            add($sformatf("starve_f%0d", i), 1, F, 0, 1, P, 1, 0, Z, e(1,0,0,0,1,F,0,0,0));
            add($sformatf("starve_r%0d", i), 1, F, 0, 1, P, 1, 1, F, e(0,1,0,0,0,F,0,1,0));
        end
        add("starve_p",     1, F, 0, 1, P, 1, 0, Z, e(0,0,1,0,1,P,0,0,0));
        add("starve_pre",   1, F, 0, 1, P, 1, 0, Z, e(0,0,0,0,0,P,1,1,0));
        add("starve_f5",    1, F, 0, 1, P, 1, 0, Z, e(1,0,0,0,1,F,0,0,0));
        add("kill_noresp",  0, Z, 1, 0, Z, 1, 0, Z, e(0,0,0,0,0,F,1,1,0));
        add("after_kill",   0, Z, 0, 0, Z, 1, 0, Z, e(0,0,0,0,0,Z,0,0,0));
        // pre-empt of an in-flight prefetch
        add("pre_pgrant",   0, Z,        0, 1, 40'h2000, 1, 0, Z,        e(0,0,1,0,1,40'h2000,0,0,0));
        add("pre_kill",     1, 40'h3000, 0, 0, Z,        1, 0, Z,        e(0,0,0,0,0,40'h2000,1,1,0));
        add("pre_fgrant",   1, 40'h3000, 0, 0, Z,        1, 0, Z,        e(1,0,0,0,1,40'h3000,0,0,0));
        add("pre_resp",     0, Z,        0, 0, Z,        1, 1, 40'h3000, e(0,1,0,0,0,40'h3000,0,1,0));
        // merge of a fetch into the same-line prefetch
        add("mrg_pgrant",   0, Z,        0, 1, 40'h2000, 1, 0, Z,        e(0,0,1,0,1,40'h2000,0,0,0));
        add("mrg_accept",   1, 40'h2008, 0, 0, Z,        1, 0, Z,        e(1,0,0,0,0,40'h2000,0,1,0));
        add("mrg_other",    0, Z,        0, 0, Z,        1, 1, 40'h9000, e(0,0,0,0,0,40'h2000,0,1,0));
        add("mrg_resp",     0, Z,        0, 0, Z,        1, 1, 40'h2000, e(0,1,0,1,0,40'h2000,0,1,0));
        add("mrg_idle",     0, Z,        0, 0, Z,        1, 0, Z,        e(0,0,0,0,0,Z,0,0,0));
        // merge abandoned by a flush: no icache kill, prefetch still answered
        add("mk_pgrant",    0, Z,        0, 1, 40'h2000, 1, 0, Z,        e(0,0,1,0,1,40'h2000,0,0,0));
        add("mk_accept",    1, 40'h2004, 0, 0, Z,        1, 0, Z,        e(1,0,0,0,0,40'h2000,0,1,0));
        add("mk_flush",     0, Z,        1, 0, Z,        1, 0, Z,        e(0,0,0,0,0,40'h2000,0,1,0));
        add("mk_resp",      0, Z,        0, 0, Z,        1, 1, 40'h2000, e(0,0,0,1,0,40'h2000,0,1,0));
        // kill and matching response in the same cycle: response wins
        add("kr_grant",     1, 40'h4000, 0, 0, Z,        1, 0, Z,        e(1,0,0,0,1,40'h4000,0,0,0));
        add("kr_both",      0, Z,        1, 0, Z,        1, 1, 40'h400c, e(0,1,0,0,0,40'h4000,0,1,0));
        add("kr_idle",      0, Z,        0, 0, Z,        1, 0, Z,        e(0,0,0,0,0,Z,0,0,0));

        #12;
        exp_q.push_back('0);
        check("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        foreach (tbl[i]) apply(tbl[i]);

        // reset while a request is outstanding returns straight to IDLE without a kill
        tbl.delete();
        add("rw_grant", 1, 40'h7000, 0, 0, Z, 1, 0, Z, e(1,0,0,0,1,40'h7000,0,0,0));
        add("rw_wait",  0, Z,        0, 0, Z, 1, 0, Z, e(0,0,0,0,0,40'h7000,0,1,0));
        apply(tbl[0]);
        apply(tbl[1]);
        rst_i = 1'b1;
        exp_q.push_back('0);
        #1;
        check("rst_mid_wait");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

`ifdef ICACHE_ARB_TIMEOUT_EN
        tbl.delete();
        add("to_grant", 1, 40'h6000, 0, 0, Z, 1, 0, Z, e(1,0,0,0,1,40'h6000,0,0,0));
        apply(tbl[0]);
        for (int i = 1; i <= 7; i++) begin
            v = '{name: $sformatf("to_wait%0d", i), fv: 0, fa: Z, fk: 0, pv: 0, pa: Z, ir: 1,
                  rv: 0, ra: Z, exp: e(0,0,0,0,0,40'h6000,0,1,0)};
            apply(v);
        end
        v = '{name: "to_fire", fv: 0, fa: Z, fk: 0, pv: 0, pa: Z, ir: 1, rv: 0, ra: Z,
              exp: e(0,0,0,0,0,40'h6000,1,1,0)};
        apply(v);
        v = '{name: "to_sticky1", fv: 0, fa: Z, fk: 0, pv: 0, pa: Z, ir: 1, rv: 0, ra: Z,
              exp: e(0,0,0,0,0,Z,0,0,1)};
        apply(v);
        v.name = "to_sticky2";
        apply(v);
        rst_i = 1'b1;
        exp_q.push_back('0);
        #1;
        check("to_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
